// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART transmitter/receiver.
//   WORD_W               : width of one data word / FIFO entry
//   DEFAULT_DELAY_FRAMES : clocks per bit (27 MHz / 9600 baud)
//   tx_state_t           : TX FSM encoding, also exported on state_out
//   rx_state_t           : RX FSM encoding (internal to uart_rx_core)
package uart_pkg;

  localparam int WORD_W               = 8;
  localparam int DEFAULT_DELAY_FRAMES = 2812;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3,
    TX_GAP   = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core -- 8N1 serial receiver.
// Optional feature: define UART_RX_STOP_CHECK_EN to reject frames whose stop
// bit samples low (comm_err set, data_ready cleared, rx_data kept). Without
// the macro comm_err is tied 0 and every frame is accepted.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   rx_pin      : asynchronous serial input
//   rx_data     : last accepted byte
//   data_ready  : level, rx_data holds a valid byte (cleared on next start edge)
//   comm_err    : level, last frame had a bad stop bit (cleared on next start edge)
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int BIT_PER_WORD = 7,
  parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_pin,
  output logic [WORD_W-1:0] rx_data,
  output logic              data_ready,
  output logic              comm_err
);

  localparam int DLY_W = $clog2(DELAY_FRAMES + 1);
  localparam int BIT_W = $clog2(BIT_PER_WORD + 1);
  localparam logic [DLY_W-1:0] BIT_LAST  = DLY_W'(DELAY_FRAMES - 1);
  localparam logic [DLY_W-1:0] HALF_LAST = DLY_W'(DELAY_FRAMES / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(BIT_PER_WORD);

`ifdef UART_RX_STOP_CHECK_EN
  localparam bit STOP_CHECK = 1'b1;
`else
  localparam bit STOP_CHECK = 1'b0;
`endif

  logic              sync_meta, rx_sync, rx_prev;
  logic              fall, bit_done, stop_ok;
  logic [DLY_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic [WORD_W-1:0] shreg;
  logic              comm_err_q;
  rx_state_t         state, state_d;

  // Two synchronizer flops, plus one more to see the falling edge of the
  // synchronized line. All reset high so reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
    end else begin
      sync_meta <= rx_pin;
      rx_sync   <= sync_meta;
      rx_prev   <= rx_sync;
    end
  end

  assign fall     = rx_prev & ~rx_sync;
  assign bit_done = (cnt == BIT_LAST);
  assign stop_ok  = rx_sync | ~STOP_CHECK;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; otherwise a latch would be inferred.
  always_comb begin
    state_d = state;
    case (state)
      RX_IDLE:  if (fall) state_d = RX_START;
      // Mid-start re-sample: a line back high means a glitch, not a frame.
      RX_START: if (cnt == HALF_LAST) state_d = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_done && bit_idx == LAST_BIT) state_d = RX_STOP;
      RX_STOP:  if (bit_done) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      data_ready <= 1'b0;
      comm_err_q <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (fall) begin
            data_ready <= 1'b0;
            comm_err_q <= 1'b0;
          end
        end
        RX_START: cnt <= (cnt == HALF_LAST) ? '0 : cnt + DLY_W'(1);
        RX_DATA: begin
          if (bit_done) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[WORD_W-1:1]};   // LSB arrives first
            bit_idx <= bit_idx + BIT_W'(1);
          end else begin
            cnt <= cnt + DLY_W'(1);
          end
        end
        RX_STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (stop_ok) begin
              rx_data    <= shreg;
              data_ready <= 1'b1;
              comm_err_q <= 1'b0;
            end else begin
              data_ready <= 1'b0;
              comm_err_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + DLY_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign comm_err = STOP_CHECK & comm_err_q;

endmodule

// File: rtl/uart_txrx.sv
// uart_txrx -- full-duplex 8N1 UART: TX FIFO + transmitter, and receiver.
// Optional feature: UART_RX_STOP_CHECK_EN enables stop-bit checking in the
// receiver (see uart_rx_core).
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   data_in, data_clk    : TX byte and write strobe (rising edge enqueues)
//   busy, idle           : FIFO full; FIFO empty and transmitter idle
//   tx, state_out        : serial output (idle high), TX FSM state
//   led_tx               : ~{busy, idle}
//   rx_pin               : asynchronous serial input
//   rx_data, data_ready, comm_err : receiver outputs
//   led_rx               : ~rx_data[3:0]
module uart_txrx
  import uart_pkg::*;
#(
  parameter int BIT_PER_WORD = 7,
  parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
  parameter int BUFFER_SIZE  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_clk,
  output logic              busy,
  output logic              idle,
  output logic              tx,
  output logic [2:0]        state_out,
  output logic [1:0]        led_tx,
  input  logic              rx_pin,
  output logic [WORD_W-1:0] rx_data,
  output logic              data_ready,
  output logic              comm_err,
  output logic [3:0]        led_rx
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam int DLY_W = $clog2(DELAY_FRAMES + 1);
  localparam int BIT_W = $clog2(BIT_PER_WORD + 1);
  localparam logic [DLY_W-1:0] BIT_LAST = DLY_W'(DELAY_FRAMES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BIT_PER_WORD);

  logic              data_clk_q, write, push, pop;
  logic [WORD_W-1:0] mem [BUFFER_SIZE];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DLY_W-1:0]  clk_cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic [WORD_W-1:0] shifter;
  logic              bit_done;
  tx_state_t         state, state_d;

  // ---------------- TX FIFO ----------------
  assign write = data_clk & ~data_clk_q;
  assign push  = write & ~busy;             // writes while full are dropped
  assign busy  = (count == CNT_W'(BUFFER_SIZE));
  assign idle  = (count == '0) && (state == TX_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_clk_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      data_clk_q <= data_clk;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // NOTE: storage is deliberately not reset; emptiness is tracked by count,
  // so stale entries are never read and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // ---------------- TX FSM ----------------
  assign bit_done = (clk_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= TX_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      TX_IDLE: if (count != '0) begin
        pop     = 1'b1;
        state_d = TX_START;
      end
      TX_START: if (bit_done) state_d = TX_DATA;
      TX_DATA:  if (bit_done && bit_idx == LAST_BIT) state_d = TX_STOP;
      TX_STOP:  if (bit_done) state_d = TX_GAP;
      TX_GAP:   if (bit_done) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_cnt <= '0;
      bit_idx <= '0;
      shifter <= '0;
    end else if (pop) begin
      shifter <= mem[rd_ptr];
      clk_cnt <= '0;
      bit_idx <= '0;
    end else if (state != TX_IDLE) begin
      if (bit_done) begin
        clk_cnt <= '0;
        if (state == TX_DATA) begin
          shifter <= shifter >> 1;
          bit_idx <= bit_idx + BIT_W'(1);
        end
      end else begin
        clk_cnt <= clk_cnt + DLY_W'(1);
      end
    end
  end

  // tx decoded from state so it is high the cycle after reset or IDLE entry.
  always_comb begin
    case (state)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = shifter[0];
      default:  tx = 1'b1;
    endcase
  end

  assign state_out = state;
  assign led_tx    = ~{busy, idle};

  // ---------------- RX ----------------
  uart_rx_core #(
    .BIT_PER_WORD (BIT_PER_WORD),
    .DELAY_FRAMES (DELAY_FRAMES)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_pin     (rx_pin),
    .rx_data    (rx_data),
    .data_ready (data_ready),
    .comm_err   (comm_err)
  );

  assign led_rx = ~rx_data[3:0];

endmodule

// File: tb/tb_uart_txrx.sv
// tb_uart_txrx -- directed bench for uart_txrx with DELAY_FRAMES=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_txrx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_clk = 1'b0;
  logic       busy, idle, tx;
  logic [2:0] state_out;
  logic [1:0] led_tx;
  logic       rx_pin = 1'b1;
  logic [7:0] rx_data;
  logic       data_ready, comm_err;
  logic [3:0] led_rx;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] got [17];
  logic       got_ok [17];
  logic [7:0] rx_expect;

  uart_txrx #(.DELAY_FRAMES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_clk   (data_clk),
    .busy       (busy),
    .idle       (idle),
    .tx         (tx),
    .state_out  (state_out),
    .led_tx     (led_tx),
    .rx_pin     (rx_pin),
    .rx_data    (rx_data),
    .data_ready (data_ready),
    .comm_err   (comm_err),
    .led_rx     (led_rx)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    data_in  = b;
    data_clk = 1'b1;
    tick();
    data_clk = 1'b0;
    tick();
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_pin = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      tick(8);
    end
    rx_pin = stop;
    tick(8);
    rx_pin = 1'b1;
  endtask

  // Bench-side UART decoder on tx: waits (bounded) for a start bit, then
  // samples each bit at its middle.
  task automatic decode_tx(output logic [7:0] b, output logic found);
    found = 1'b0;
    b     = 8'h00;
    for (int i = 0; i < 200; i++) begin
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (found) begin
      tick(4);
      for (int j = 0; j < 8; j++) begin
        tick(8);
        b[j] = tx;
      end
      tick(8);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %b want 1", idle); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (state_out !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state_out); end
    vectors++; if (led_tx !== 2'b10) begin miscompares++; $display("FAIL reset_led_tx: got %b want 10", led_tx); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL reset_data_ready: got %b want 0", data_ready); end
    vectors++; if (comm_err !== 1'b0) begin miscompares++; $display("FAIL reset_comm_err: got %b want 0", comm_err); end
    vectors++; if (led_rx !== 4'hF) begin miscompares++; $display("FAIL reset_led_rx: got %b want 1111", led_rx); end
  endtask

  // 0x45: start 0, data 1,0,1,0,0,0,1,0, stop 1, gap 1 -- 8 clocks each.
  task automatic test_tx_single();
    logic [10:0] frame;
    frame = {2'b11, 8'h45, 1'b0};
    write_byte(8'h45);
    vectors++; if (state_out !== 3'd1) begin miscompares++; $display("FAIL tx1_state_start: got %0d want 1", state_out); end
    vectors++; if (idle !== 1'b0) begin miscompares++; $display("FAIL tx1_idle_busy: got %b want 0", idle); end
    vectors++; if (led_tx !== 2'b11) begin miscompares++; $display("FAIL tx1_led_tx: got %b want 11", led_tx); end
    for (int k = 0; k < 88; k++) begin
      vectors++;
      if (tx !== frame[k/8]) begin
        miscompares++;
        $display("FAIL tx1_wave cycle %0d: got %b want %b", k, tx, frame[k/8]);
      end
      tick();
    end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL tx1_idle_after: got %b want 1", idle); end
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL tx1_tx_after: got %b want 1", tx); end
  endtask

  // 20 writes every 2 clocks: byte 0 is popped at once, bytes 1..16 fill the
  // FIFO, bytes 17..19 (0x21..0x23) are dropped.
  task automatic test_fifo_full();
    logic [7:0] extra;
    logic       extra_found;
    fork
      begin
        for (int i = 0; i < 20; i++) write_byte(8'(8'h10 + i));
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fifo_busy: got %b want 1", busy); end
        vectors++; if (led_tx !== 2'b01) begin miscompares++; $display("FAIL fifo_led_tx: got %b want 01", led_tx); end
      end
      begin
        for (int f = 0; f < 17; f++) decode_tx(got[f], got_ok[f]);
      end
    join
    for (int f = 0; f < 17; f++) begin
      vectors++;
      if (got_ok[f] !== 1'b1 || got[f] !== 8'(8'h10 + f)) begin
        miscompares++;
        $display("FAIL fifo_order frame %0d: got %h (found %b) want %h", f, got[f], got_ok[f], 8'(8'h10 + f));
      end
    end
    decode_tx(extra, extra_found);
    vectors++; if (extra_found !== 1'b0) begin miscompares++; $display("FAIL fifo_extra_frame: got frame %h want none", extra); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL fifo_idle_end: got %b want 1", idle); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL fifo_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_rx_good();
    send_rx(8'h31, 1'b1);
    tick(2);
    rx_expect = 8'h31;
    vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL rx_good_ready: got %b want 1", data_ready); end
    vectors++; if (rx_data !== 8'h31) begin miscompares++; $display("FAIL rx_good_data: got %h want 31", rx_data); end
    vectors++; if (comm_err !== 1'b0) begin miscompares++; $display("FAIL rx_good_err: got %b want 0", comm_err); end
    vectors++; if (led_rx !== 4'b1110) begin miscompares++; $display("FAIL rx_good_led: got %b want 1110", led_rx); end
  endtask

  task automatic test_rx_bad_stop();
    logic       exp_ready, exp_err;
    send_rx(8'hA5, 1'b0);
    tick(4);
`ifdef UART_RX_STOP_CHECK_EN
    exp_ready = 1'b0;
    exp_err   = 1'b1;
`else
    exp_ready = 1'b1;
    exp_err   = 1'b0;
    rx_expect = 8'hA5;
`endif
    vectors++; if (comm_err !== exp_err) begin miscompares++; $display("FAIL rx_bad_err: got %b want %b", comm_err, exp_err); end
    vectors++; if (data_ready !== exp_ready) begin miscompares++; $display("FAIL rx_bad_ready: got %b want %b", data_ready, exp_ready); end
    vectors++; if (rx_data !== rx_expect) begin miscompares++; $display("FAIL rx_bad_data: got %h want %h", rx_data, rx_expect); end
    tick(8);
  endtask

  // A 3-clock low pulse arms the receiver (clearing the status flags) but is
  // rejected at the mid-start re-sample.
  task automatic test_rx_glitch();
    logic saw_ready, saw_err;
    saw_ready = 1'b0;
    saw_err   = 1'b0;
    rx_pin = 1'b0;
    tick(3);
    rx_pin = 1'b1;
    for (int i = 0; i < 40; i++) begin
      saw_ready |= data_ready;
      saw_err   |= comm_err;
      tick();
    end
    vectors++; if (saw_ready !== 1'b0) begin miscompares++; $display("FAIL glitch_ready: got %b want 0", saw_ready); end
    vectors++; if (saw_err !== 1'b0) begin miscompares++; $display("FAIL glitch_err: got %b want 0", saw_err); end
    vectors++; if (rx_data !== rx_expect) begin miscompares++; $display("FAIL glitch_data: got %h want %h", rx_data, rx_expect); end
  endtask

  task automatic test_reset_mid_frame();
    int low_cycles;
    for (int i = 0; i < 4; i++) write_byte(8'h00);
    tick(20);
    vectors++; if (state_out !== 3'd2) begin miscompares++; $display("FAIL rst_mid_in_data: got %0d want 2", state_out); end
    rst_n = 1'b0;
    tick();
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL rst_mid_idle: got %b want 1", idle); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    vectors++; if (state_out !== 3'd0) begin miscompares++; $display("FAIL rst_mid_state: got %0d want 0", state_out); end
    rst_n = 1'b1;
    low_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx !== 1'b1) low_cycles++;
    end
    vectors++; if (low_cycles !== 0) begin miscompares++; $display("FAIL rst_mid_silent: got %0d low cycles want 0", low_cycles); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL rst_mid_idle_after: got %b want 1", idle); end
  endtask

  initial begin
    rx_expect = 8'h00;
    tick();
    test_reset();
    test_tx_single();
    test_fifo_full();
    test_rx_good();
    test_rx_bad_stop();
    test_rx_glitch();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_txrx.md
UART_TXRX -- requirements
Module: uart_txrx

Interface
REQ-001 SHALL have parameter BIT_PER_WORD, default 7: index of the MSB data bit, so a frame carries BIT_PER_WORD+1 data bits.
REQ-002 SHALL have parameter DELAY_FRAMES, default 2812: clocks per bit (27 MHz / 9600 baud).
REQ-003 SHALL have parameter BUFFER_SIZE, default 16: TX FIFO depth in words, a power of two.
REQ-004 clk  in  1  sole clock; all logic on posedge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 data_in  in  8  TX byte to enqueue.
REQ-007 data_clk  in  1  TX write strobe; a 0->1 transition, sampled in clk, enqueues data_in.
REQ-008 busy  out  1  TX FIFO full.
REQ-009 idle  out  1  TX FIFO empty and transmitter in IDLE.
REQ-010 tx  out  1  serial output, idle high.
REQ-011 state_out  out  3  TX state encoding.
REQ-012 led_tx  out  2  ~{busy, idle}, for active-low LEDs.
REQ-013 rx_pin  in  1  asynchronous serial input.
REQ-014 rx_data  out  8  last received byte.
REQ-015 data_ready  out  1  level; valid byte in rx_data.
REQ-016 comm_err  out  1  level; last frame had a bad stop bit.
REQ-017 led_rx  out  4  ~rx_data[3:0].

Function
REQ-018 Frame format SHALL be 8N1: one low start bit, data LSB first, one high stop bit; each bit held DELAY_FRAMES clocks.
REQ-019 data_clk SHALL be registered; write = data_clk & ~data_clk_q; a write while busy=1 SHALL be dropped, with FIFO contents unchanged.
REQ-020 FIFO SHALL keep a count 0..BUFFER_SIZE with wrapping read/write pointers; a simultaneous push and pop SHALL leave the count unchanged.
REQ-021 TX FSM states SHALL be IDLE=0, START=1, DATA=2, STOP=3, GAP=4.
REQ-022 IDLE with FIFO non-empty: pop the head byte into the shifter and go to START; tx SHALL go low on the next cycle.
REQ-023 START -> DATA -> STOP -> GAP, each after DELAY_FRAMES clocks; DATA spans BIT_PER_WORD+1 bit times.
REQ-024 GAP SHALL hold tx high for one bit time, then return to IDLE.
REQ-025 The RX path SHALL pass rx_pin through a 2-flop synchronizer before any use.
REQ-026 RX in idle SHALL arm on a synchronized 1->0 edge, wait DELAY_FRAMES/2 clocks, and re-sample; a high sample SHALL abort to idle without asserting any output.
REQ-027 RX SHALL then sample each data bit at DELAY_FRAMES intervals, then the stop bit one interval later.
REQ-028 Stop bit high: rx_data <= shifted byte, data_ready <= 1, and comm_err <= 0, all on the same cycle.
REQ-029 Stop bit low: comm_err <= 1, data_ready <= 0, and rx_data unchanged.
REQ-030 data_ready and comm_err SHALL hold until the next start edge is detected, then clear.
REQ-031 TX and RX SHALL be fully independent (full duplex).

Reset
REQ-032 With rst_n=0 at a clk edge, the block SHALL set: FIFO empty, pointers 0, TX IDLE, tx=1, busy=0, idle=1, data_clk_q=0, rx_data=0, data_ready=0, comm_err=0, RX idle, synchronizer flops=1.
REQ-033 Reset mid-frame SHALL abort the frame; tx SHALL be high on the following cycle, with no partial byte kept.

Configuration
REQ-034 With macro UART_RX_STOP_CHECK_EN defined, REQ-029 SHALL apply.
REQ-035 Without UART_RX_STOP_CHECK_EN, comm_err SHALL be tied 0 and every frame SHALL be accepted per REQ-028, regardless of the stop-bit level.

Structure
REQ-036 The TX state encodings, the 8-bit word width, and the default DELAY_FRAMES SHALL live in shared package uart_pkg.
REQ-037 The RX receiver SHALL be a sub-module uart_rx_core; the FIFO and TX FSM SHALL stay in uart_txrx.

Verification (DELAY_FRAMES=8)
REQ-038 Write 0x45 -> tx: low 8 clk, then bits 1,0,1,0,0,0,1,0 for 8 clk each, high stop, high gap; idle=1 afterwards.
REQ-039 Write 20 bytes, one per 2 clk -> busy rises while full; dropped bytes never appear; output order equals accepted order.
REQ-040 Drive rx frame 0x31 -> data_ready=1, rx_data=0x31, comm_err=0 after stop sample; led_rx=4'b1110.
REQ-041 Drive rx frame 0xA5 with a low stop bit -> comm_err=1, data_ready=0, rx_data unchanged.
REQ-042 Drive a 3-clk low glitch on rx_pin -> no data_ready, no comm_err.
REQ-043 Assert rst_n=0 mid-DATA with 3 bytes queued -> tx=1, idle=1, busy=0 next cycle; nothing transmitted after release.
